qar_spi_arbiter: RTL and testbench

//  Shares the single byte-level SPI master engine of qar_core among N_REQ requesters (CPU MMIO port, boot/flash fetcher, DMA).

---
 rtl/qar_spi_pkg.sv | 30 +++
 rtl/qar_spi_arbiter_rr.sv | 55 +++++
 rtl/qar_spi_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_qar_spi_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qar_spi_pkg.sv
// ---------------------------------------------------------------------------
// qar_spi_pkg
// Shared constants for the SPI requester arbiter:
//   CS_WIDTH   number of physical chip-select lines
//   BYTE_W     width of one SPI transfer
//   ST_*       arbiter FSM state encoding
//   max4()     helper used to size the shared phase counter
// ---------------------------------------------------------------------------
package qar_spi_pkg;

    localparam int CS_WIDTH = 4;
    localparam int BYTE_W   = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/qar_spi_arbiter_rr.sv
// ---------------------------------------------------------------------------
// qar_rr_arbiter
// N-way round-robin picker. The candidate is the first requester at or after
// rr_ptr (wrapping). rr_ptr moves to candidate+1 only when the caller accepts.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (rr_ptr -> 0)
//   req          request vector
//   accept       candidate taken this cycle; advance rr_ptr
//   grant_oh     one-hot candidate (0 when no request)
//   grant_idx    binary index of the candidate
// ---------------------------------------------------------------------------
module qar_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant_oh,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] rr_ptr;

    // Scan from the farthest offset down to offset 0 so that the requester
    // closest to rr_ptr is the last one written and therefore wins.
    always_comb begin
        int            sum;
        logic [PW-1:0] idx;
        sum       = 0;
        idx       = '0;
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= N) sum = sum - N;
            idx = PW'(sum);
            if (req[idx]) begin
                grant_oh      = '0;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/qar_spi_arbiter.sv
// ---------------------------------------------------------------------------
// qar_spi_arbiter
// Shares one byte-level SPI engine among N_REQ requesters. Each grant is an
// atomic burst: chip-select stays low from the first byte until the byte
// flagged last, with setup / hold / minimum-gap timing around it and a
// watchdog that aborts a burst whose owner stops presenting bytes.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/data/last   per-requester TX byte stream
//   req_cs                per-requester CS index, sampled at grant only
//   req_ready             byte accepted (owner only, during ISSUE)
//   grant                 one-hot current owner
//   rsp_valid/data/last   RX byte returned to the owner (one-cycle pulse)
//   err_tmo               one-cycle pulse when the watchdog aborts a burst
//   eng_start/tx          engine command (combinational, ISSUE only)
//   eng_done/rx           engine completion
//   spi_cs_n              active-low chip selects
//
// Handshake: a requester byte transfers on a clk edge where req_valid[i] and
// req_ready[i] are both high. req_valid may rise at any time and must hold
// data/last stable until accepted; req_ready depends on req_valid, never the
// reverse. eng_start is the same event seen from the engine side.
// ---------------------------------------------------------------------------
module qar_spi_arbiter
    import qar_spi_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4,
    parameter int IDLE_TMO = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [2*N_REQ-1:0]        req_cs,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [BYTE_W-1:0]         rsp_data,
    output logic                      rsp_last,
    output logic                      err_tmo,
    output logic                      eng_start,
    output logic [BYTE_W-1:0]         eng_tx,
    input  logic                      eng_done,
    input  logic [BYTE_W-1:0]         eng_rx,
    output logic [CS_WIDTH-1:0]       spi_cs_n
);

    localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = max4(CS_SETUP, CS_HOLD, CS_GAP, IDLE_TMO);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Each phase ends when the shared counter reaches (length - 1).
    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] TMO_END   = CW'(IDLE_TMO - 1);

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [OW-1:0]     owner;
    logic              last_q;

    logic [N_REQ-1:0]  arb_grant;
    logic [OW-1:0]     arb_idx;
    logic              arb_accept;

    logic              owner_valid;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_data;
    logic [1:0]        cand_cs;

    assign arb_accept = (state == ST_IDLE) && (|req_valid);

    qar_rr_arbiter #(.N(N_REQ), .PW(OW)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .accept    (arb_accept),
        .grant_oh  (arb_grant),
        .grant_idx (arb_idx)
    );

    // Owner-side views of the request bus, plus the CS index of the
    // candidate about to be granted.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        cand_cs     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == OW'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*BYTE_W +: BYTE_W];
            end
            if (arb_idx == OW'(i)) cand_cs = req_cs[2*i +: 2];
        end
    end

    // Accept and launch in the same ISSUE cycle so a byte costs one ISSUE
    // cycle plus engine latency.
    always_comb begin
        req_ready = '0;
        eng_start = 1'b0;
        eng_tx    = '0;
        if (state == ST_ISSUE && owner_valid) begin
            eng_start = 1'b1;
            eng_tx    = owner_data;
            for (int i = 0; i < N_REQ; i++) begin
                req_ready[i] = (owner == OW'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner     <= '0;
            last_q    <= 1'b0;
            grant     <= '0;
            spi_cs_n  <= '1;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            err_tmo   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant    <= arb_grant;
                        owner    <= arb_idx;
                        spi_cs_n <= ~(CS_WIDTH'(1) << cand_cs);
                        cnt      <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt   <= '0;
                        state <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (owner_valid) begin
                        last_q <= owner_last;
                        cnt    <= '0;
                        state  <= ST_BUSY;
                    end else if (cnt == TMO_END) begin
                        // Owner went quiet mid-burst: abort without a response.
                        err_tmo <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (eng_done) begin
                        rsp_valid <= grant;
                        rsp_data  <= eng_rx;
                        rsp_last  <= last_q;
                        cnt       <= '0;
                        state     <= last_q ? ST_HOLD : ST_ISSUE;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_END) begin
                        spi_cs_n <= '1;
                        grant    <= '0;
                        cnt      <= '0;
                        state    <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_END) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qar_spi_arbiter.sv
module tb_qar_spi_arbiter;

    localparam int N_REQ    = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
    localparam int IDLE_TMO = 255;
    localparam int EW       = N_REQ + 1 + 8;
    localparam int BUDGET   = 1000;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_last;
    logic [2*N_REQ-1:0]   req_cs;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     rsp_valid;
    logic [7:0]           rsp_data;
    logic                 rsp_last;
    logic                 err_tmo;
    logic                 eng_start;
    logic [7:0]           eng_tx;
    logic                 eng_done;
    logic [7:0]           eng_rx;
    logic [3:0]           spi_cs_n;

    qar_spi_arbiter #(
        .N_REQ(N_REQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
        .CS_GAP(CS_GAP), .IDLE_TMO(IDLE_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_cs(req_cs),
        .req_ready(req_ready), .grant(grant),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .err_tmo(err_tmo),
        .eng_start(eng_start), .eng_tx(eng_tx), .eng_done(eng_done), .eng_rx(eng_rx),
        .spi_cs_n(spi_cs_n)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural SPI engine ----------------
    // done 8 cycles after start, rx = tx ^ 8'hFF; shares rst_n
    logic       eng_busy;
    logic [3:0] eng_cnt;
    logic [7:0] eng_sh;
    always @(posedge clk) begin
        if (!rst_n) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 4'd0;
            eng_sh   <= 8'h00;
            eng_done <= 1'b0;
            eng_rx   <= 8'h00;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 4'd7;
                eng_sh   <= eng_tx;
            end else if (eng_busy) begin
                if (eng_cnt == 4'd1) begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                    eng_rx   <= eng_sh ^ 8'hFF;
                end else begin
                    eng_cnt <= eng_cnt - 4'd1;
                end
            end
        end
    end

    // ---------------- counters, scoreboard, monitors ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    int tick_no = 0;
    int last_rsp_tick = -1;
    int last_err_tick = -1;
    int rsp_count = 0;
    int err_count = 0;
    int ready_bad = 0;
    int setup_cnt = 0, setup_meas = -1;
    int hold_cnt = 0, hold_meas = -1;
    int gap_cnt = 1000, gap_meas = -1;
    bit arm_setup = 0, arm_hold = 0, cs_low_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock step; all waiting goes through here so the scoreboard and
    // timing monitors see every cycle.
    task automatic tick();
        bit cs_low;
        logic [EW-1:0] e;
        @(negedge clk);
        if (rsp_valid != '0) begin
            rsp_count++;
            last_rsp_tick = tick_no;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got 0x%0h, expected no response",
                         {rsp_valid, rsp_last, rsp_data});
            end else begin
                e = exp_q.pop_front();
                check("rsp", 32'({rsp_valid, rsp_last, rsp_data}), 32'(e));
            end
        end
        if (err_tmo) begin
            err_count++;
            last_err_tick = tick_no;
        end
        if (((req_ready & ~grant) != '0) || ($countones(req_ready) > 1) ||
            (eng_start && (req_ready == '0)))
            ready_bad++;
        cs_low = (spi_cs_n != 4'hF);
        if (!rst_n) begin
            arm_setup = 0;
            arm_hold  = 0;
        end
        if (cs_low && !cs_low_prev) begin
            gap_meas  = gap_cnt;
            setup_cnt = 0;
            arm_setup = 1;
        end
        if (cs_low) gap_cnt = 0;
        else gap_cnt++;
        if (arm_setup && cs_low) begin
            if (eng_start) begin
                setup_meas = setup_cnt;
                arm_setup  = 0;
            end else begin
                setup_cnt++;
            end
        end
        if (eng_start) arm_hold = 0;
        if (arm_hold) begin
            if (cs_low) hold_cnt++;
            else begin
                hold_meas = hold_cnt;
                arm_hold  = 0;
            end
        end
        if (eng_done) begin
            arm_hold = 1;
            hold_cnt = 0;
        end
        cs_low_prev = cs_low;
        tick_no++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic present(input int r, input logic [7:0] d, input logic l, input logic [1:0] cs);
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = d;
        req_last[r]        = l;
        req_cs[2*r +: 2]   = cs;
    endtask

    // Drive a whole burst for requester r and check grant, CS and handshake.
    // other_r >= 0 raises that requester's request once r owns the bus.
    task automatic run_burst(input int r, input logic [1:0] cs, input int n,
                             input logic [31:0] tx, input logic [3:0] exp_csn,
                             input logic [31:0] exp_rx, input int other_r,
                             input logic [7:0] other_tx, input logic [1:0] other_cs);
        int sent, cyc, bad;
        logic [N_REQ-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        for (int i = 0; i < n; i++)
            exp_q.push_back({oh, (i == n - 1), exp_rx[8*i +: 8]});
        present(r, tx[7:0], (n == 1), cs);
        cyc = 0;
        while (grant == '0 && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check($sformatf("grant_r%0d", r), 32'(grant), 32'(oh));
        // A CS change after grant must not move the chip select.
        req_cs[2*r +: 2] = ~cs;
        if (other_r >= 0) present(other_r, other_tx, 1'b1, other_cs);
        sent = 0;
        bad  = 0;
        while (sent < n && cyc < BUDGET) begin
            if (spi_cs_n !== exp_csn) bad++;
            if (req_ready[r]) begin
                @(posedge clk);
                #1;
                sent++;
                if (sent < n) present(r, tx[8*sent +: 8], (sent == n - 1), ~cs);
                else req_valid[r] = 1'b0;
            end
            tick();
            cyc++;
        end
        while (grant != '0 && cyc < BUDGET) begin
            if (spi_cs_n !== exp_csn) bad++;
            tick();
            cyc++;
        end
        check($sformatf("bytes_sent_r%0d", r), 32'(sent), 32'(n));
        check($sformatf("cs_held_r%0d", r), 32'(bad), 32'd0);
        check($sformatf("cs_released_r%0d", r), 32'(spi_cs_n), 32'hF);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         r;
        logic [1:0] cs;
        int         n;
        logic [31:0] tx;
        logic [3:0] exp_csn;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int c;
        int rc0, ec0;

        vecs[0] = '{r: 0, cs: 2'd1, n: 2, tx: 32'h0000_3CA5, exp_csn: 4'hD, exp_rx: 32'h0000_C35A};
        vecs[1] = '{r: 1, cs: 2'd2, n: 3, tx: 32'h0081_FF00, exp_csn: 4'hB, exp_rx: 32'h007E_00FF};
        vecs[2] = '{r: 0, cs: 2'd3, n: 1, tx: 32'h0000_0096, exp_csn: 4'h7, exp_rx: 32'h0000_0069};
        vecs[3] = '{r: 1, cs: 2'd0, n: 4, tx: 32'h7856_3412, exp_csn: 4'hE, exp_rx: 32'h87A9_CBED};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        req_cs    = '0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_cs_n", 32'(spi_cs_n), 32'hF);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_eng_start_err", 32'({eng_start, err_tmo}), 32'd0);
        check("rst_data", 32'({rsp_data, eng_tx}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single bursts from the table, one requester at a time
        for (int v = 0; v < 4; v++) begin
            setup_meas = -1;
            hold_meas  = -1;
            run_burst(vecs[v].r, vecs[v].cs, vecs[v].n, vecs[v].tx, vecs[v].exp_csn,
                      vecs[v].exp_rx, -1, 8'h00, 2'd0);
            check($sformatf("setup_cycles_v%0d", v), 32'(setup_meas), 32'(CS_SETUP));
            check($sformatf("hold_cycles_v%0d", v), 32'(hold_meas), 32'(CS_HOLD));
        end

        // atomicity: req1 raises during req0's burst, waits its turn
        run_burst(0, 2'd1, 2, 32'h0000_1122, 4'hD, 32'h0000_EEDD, 1, 8'h42, 2'd2);
        run_burst(1, 2'd2, 1, 32'h0000_0042, 4'hB, 32'h0000_00BD, -1, 8'h00, 2'd0);
        check("gap_after_atomic", 32'(gap_meas >= CS_GAP), 32'd1);

        // contention with rr pointer at 0: req0 first, then req1
        present(0, 8'h01, 1'b1, 2'd0);
        present(1, 8'h02, 1'b1, 2'd3);
        run_burst(0, 2'd0, 1, 32'h0000_0001, 4'hE, 32'h0000_00FE, -1, 8'h00, 2'd0);
        run_burst(1, 2'd3, 1, 32'h0000_0002, 4'h7, 32'h0000_00FD, -1, 8'h00, 2'd0);
        check("gap_after_contention", 32'(gap_meas >= CS_GAP), 32'd1);

        // req0 alone moves the pointer to req1; next simultaneous round starts with req1
        run_burst(0, 2'd1, 1, 32'h0000_0080, 4'hD, 32'h0000_007F, -1, 8'h00, 2'd0);
        present(0, 8'hF0, 1'b1, 2'd1);
        present(1, 8'h0F, 1'b1, 2'd2);
        run_burst(1, 2'd2, 1, 32'h0000_000F, 4'hB, 32'h0000_00F0, -1, 8'h00, 2'd0);
        run_burst(0, 2'd1, 1, 32'h0000_00F0, 4'hD, 32'h0000_000F, -1, 8'h00, 2'd0);

        // watchdog: one byte without last, then the owner goes quiet
        exp_q.push_back({2'b01, 1'b0, 8'hEE});
        present(0, 8'h11, 1'b0, 2'd2);
        c = 0;
        while (grant == '0 && c < BUDGET) begin tick(); c++; end
        check("tmo_grant", 32'(grant), 32'd1);
        while (!req_ready[0] && c < BUDGET) begin tick(); c++; end
        check("tmo_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        ec0 = err_count;
        c = 0;
        while (!err_tmo && c < BUDGET) begin tick(); c++; end
        check("tmo_latency", 32'(last_err_tick - last_rsp_tick), 32'(IDLE_TMO));
        check("tmo_cs_during", 32'(spi_cs_n), 32'hB);
        tick();
        check("tmo_pulse_width", 32'(err_tmo), 32'd0);
        c = 1;
        while (spi_cs_n != 4'hF && c < 50) begin tick(); c++; end
        check("tmo_hold_cycles", 32'(c), 32'(CS_HOLD));
        check("tmo_err_count", 32'(err_count - ec0), 32'd1);
        repeat (CS_GAP + 2) tick();

        // reset while the engine is mid-shift
        present(0, 8'h5A, 1'b1, 2'd0);
        c = 0;
        while (grant == '0 && c < BUDGET) begin tick(); c++; end
        while (!eng_start && c < BUDGET) begin tick(); c++; end
        check("rst_busy_started", 32'(eng_start), 32'd1);
        tick();
        tick();
        tick();
        rc0 = rsp_count;
        ec0 = err_count;
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        check("rst_busy_cs_n", 32'(spi_cs_n), 32'hF);
        check("rst_busy_grant", 32'(grant), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("rst_busy_no_rsp", 32'(rsp_count - rc0), 32'd0);
        check("rst_busy_no_err", 32'(err_count - ec0), 32'd0);

        // final report
        check("non_owner_ready", 32'(ready_bad), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
